cam_row_sequencer: RTL and testbench
====================================

Name: cam_row_sequencer

Overview:
- Timing/sequencing stage directly upstream of the 2-to-4 row decoder in the CAM 9T-SRAM array.
- Accepts row write/read/scan requests over a valid/ready handshake.
- Drives the decoder inputs (I0, I1, E) plus bitline precharge, write-drive and sense-enable strobes in a fixed phase order.
- Returns read data per row.

Parameters:
- WIDTH, 8, data word width of one CAM row.
- PRE_CYCLES, 1, cycles of bitline precharge before wordline enable (>=1).
- WL_CYCLES, 2, cycles the decoder enable E is held high (>=1).
- REC_CYCLES, 1, recovery cycles after E falls before next access (>=1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op  input  2  00 write, 01 read, 10 scan-read all rows, 11 no-op.
- req_row  input  2  target row (ignored for scan/no-op).
- req_data  input  WIDTH  write data.
- dec_i0  output  1  decoder I0 (row bit 0).
- dec_i1  output  1  decoder I1 (row bit 1).
- dec_en  output  1  decoder E (wordline enable).
- pre_n  output  1  bitline precharge, active low.
- bl_drive_en  output  1  bitline write drivers on.
- bl_data  output  WIDTH  bitline write data.
- sense_en  output  1  sense-amp enable.
- rd_data  input  WIDTH  sense-amp outputs.
- rsp_valid  output  1  one-cycle read response strobe.
- rsp_row  output  2  row of the response.
- rsp_data  output  WIDTH  read data.
- busy  output  1  high in any non-IDLE state.

Behaviour:
- Reset (rst_n sampled low at clk edge):
  - req_ready=1, pre_n=1, all other outputs 0, state IDLE, counters 0.
  - Reset mid-operation aborts immediately; no response is issued.
- FSM states: IDLE, PRE, WL, REC, NOP.
- Handshake: req_ready=1 only in IDLE. Accept on an edge with req_valid && req_ready; latch op, row (0 for scan) and data.
- Op 11:
  - Go to NOP for exactly one cycle (req_ready=0, no array strobes), then IDLE.
- PRE:
  - pre_n=0 for PRE_CYCLES cycles.
  - {dec_i1,dec_i0}=latched row, held stable through PRE, WL and REC.
- WL:
  - dec_en=1, pre_n=1 for WL_CYCLES cycles.
  - Write: bl_drive_en=1, bl_data=latched data for all WL cycles.
  - Read/scan: sense_en=1 in the last WL cycle only; rd_data captured on the edge ending that cycle.
- REC:
  - dec_en, bl_drive_en and sense_en = 0 for REC_CYCLES cycles.
  - Read/scan: rsp_valid=1 in the first REC cycle with rsp_row/rsp_data; rsp_data holds until the next capture.
- After REC:
  - Scan with row<3: row+1, back to PRE.
  - Otherwise: IDLE; bl_data cleared to 0.
- Invariants:
  - dec_en never high while pre_n=0.
  - Address never changes while dec_en=1.
  - bl_drive_en and sense_en never both high.
- Latency (acceptance edge = cycle 0, N=PRE+WL+REC):
  - PRE occupies cycles 1..PRE.
  - req_ready returns in cycle N+1.
  - Read rsp_valid in cycle PRE+WL+1.
  - Scan completes in 4N cycles with 4 responses.
- req_valid during busy is ignored (not accepted); the requester must hold it.

Optional Feature:
- Macro CAM_SEQ_PARITY_EN.
- Defined:
  - Write drives bl_data as WIDTH-1 data bits plus MSB = even parity of req_data[WIDTH-2:0].
  - Read recomputes parity on rd_data; extra output rsp_err (1 bit, reset 0) = parity mismatch, valid with rsp_valid.
- Undefined:
  - bl_data = req_data unchanged.
  - No rsp_err port.

Test Plan:
- Reset, then write row 2 data 0xA5 (defaults):
  - pre_n=0 in cycle 1.
  - dec_en=1 with {i1,i0}=10 and bl_data=0xA5 in cycles 2-3.
  - req_ready=1 in cycle 5.
  - No rsp_valid.
- Read row 1, rd_data=0x3C:
  - sense_en=1 in cycle 3 only.
  - rsp_valid cycle 4 with rsp_row=1, rsp_data=0x3C.
- Scan, rd_data=0x11,0x22,0x33,0x44 per row:
  - rsp_valid in cycles 4, 8, 12, 16 with rows 0..3 and matching data.
  - req_ready in cycle 17.
- Back-to-back: req_valid held high with write then read:
  - Second accept at the cycle-5 edge.
  - dec_en low for at least PRE+REC cycles between accesses.
- rst_n low in cycle 2 of a write (during WL):
  - Next cycle dec_en=0, bl_drive_en=0, pre_n=1, req_ready=1.
  - No rsp_valid.
- Op 11: req_ready=0 for exactly one cycle, no strobes. With CAM_SEQ_PARITY_EN:
  - Read with a corrupted parity bit → rsp_err=1.
  - Read with correct parity → rsp_err=0.

Source files
------------

// File: rtl/cam_row_sequencer.sv
// Phase sequencer (precharge -> wordline -> recovery) feeding the CAM 2-to-4 row decoder.
// Define CAM_SEQ_PARITY_EN to carry even parity in the data MSB and report rsp_err on reads.
module cam_row_sequencer #(
    parameter int WIDTH      = 8,
    parameter int PRE_CYCLES = 1,
    parameter int WL_CYCLES  = 2,
    parameter int REC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [1:0]       req_row,
    input  logic [WIDTH-1:0] req_data,
    output logic             dec_i0,
    output logic             dec_i1,
    output logic             dec_en,
    output logic             pre_n,
    output logic             bl_drive_en,
    output logic [WIDTH-1:0] bl_data,
    output logic             sense_en,
    input  logic [WIDTH-1:0] rd_data,
    output logic             rsp_valid,
    output logic [1:0]       rsp_row,
    output logic [WIDTH-1:0] rsp_data,
`ifdef CAM_SEQ_PARITY_EN
    output logic             rsp_err,
`endif
    output logic             busy
);

    localparam int MAX_CYC = (PRE_CYCLES > WL_CYCLES)
                           ? ((PRE_CYCLES > REC_CYCLES) ? PRE_CYCLES : REC_CYCLES)
                           : ((WL_CYCLES > REC_CYCLES) ? WL_CYCLES : REC_CYCLES);
    localparam int CW = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(PRE_CYCLES - 1);
    localparam logic [CW-1:0] WL_LAST  = CW'(WL_CYCLES - 1);
    localparam logic [CW-1:0] REC_LAST = CW'(REC_CYCLES - 1);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SCAN  = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WL, S_REC, S_NOP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       row_q, row_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_row_q, rsp_row_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             in_access;

    // Word as it is placed on the bitlines (parity build folds the check bit into the MSB).
    function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] d);
`ifdef CAM_SEQ_PARITY_EN
        return {^d[WIDTH-2:0], d[WIDTH-2:0]};
`else
        return d;
`endif
    endfunction

    function automatic logic parity_bad(input logic [WIDTH-1:0] d);
`ifdef CAM_SEQ_PARITY_EN
        return (^d[WIDTH-2:0]) != d[WIDTH-1];
`else
        return (d != d);
`endif
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        row_d       = row_q;
        data_d      = data_q;
        rsp_valid_d = 1'b0;
        rsp_row_d   = rsp_row_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_d = '0;
                    op_d  = req_op;
                    if (req_op == OP_NOP) begin
                        state_d = S_NOP;
                    end else begin
                        state_d = S_PRE;
                        row_d   = (req_op == OP_SCAN) ? 2'd0 : req_row;
                        data_d  = encode(req_data);
                    end
                end
            end
            S_NOP: state_d = S_IDLE;
            S_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WL: begin
                if (cnt_q == WL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_REC;
                    // Sense data is taken on the edge that closes the last wordline cycle.
                    if (op_q != OP_WRITE) begin
                        rsp_valid_d = 1'b1;
                        rsp_row_d   = row_q;
                        rsp_data_d  = rd_data;
                        rsp_err_d   = parity_bad(rd_data);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REC: begin
                if (cnt_q == REC_LAST) begin
                    cnt_d = '0;
                    if (op_q == OP_SCAN && row_q != 2'd3) begin
                        row_d   = row_q + 2'd1;
                        state_d = S_PRE;
                    end else begin
                        data_d  = '0;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            row_q       <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_row_q   <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            row_q       <= row_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_row_q   <= rsp_row_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign in_access   = (state_q == S_PRE) || (state_q == S_WL) || (state_q == S_REC);
    assign req_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign pre_n       = (state_q != S_PRE);
    assign dec_en      = (state_q == S_WL);
    assign dec_i0      = in_access & row_q[0];
    assign dec_i1      = in_access & row_q[1];
    assign bl_drive_en = (state_q == S_WL) && (op_q == OP_WRITE);
    assign bl_data     = data_q;
    assign sense_en    = (state_q == S_WL) && (op_q != OP_WRITE) && (cnt_q == WL_LAST);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_row     = rsp_row_q;
    assign rsp_data    = rsp_data_q;
`ifdef CAM_SEQ_PARITY_EN
    assign rsp_err     = rsp_err_q;
`else
    logic unused_err;
    assign unused_err  = rsp_err_q;
`endif

endmodule

// File: tb/tb_cam_row_sequencer.sv
// Self-checking bench for cam_row_sequencer: timeline model of expected strobes per cycle
// plus hand-computed spot checks for each directed scenario.
module tb_cam_row_sequencer;

    localparam int W     = 8;
    localparam int P     = 1;
    localparam int WLC   = 2;
    localparam int R     = 1;
    localparam int N     = P + WLC + R;
    localparam int DEPTH = 1024;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'b0;
    logic [1:0]   req_row = 2'b0;
    logic [W-1:0] req_data = '0;
    logic         dec_i0, dec_i1, dec_en, pre_n, bl_drive_en, sense_en;
    logic [W-1:0] bl_data, rd_data, rsp_data;
    logic         rsp_valid, busy;
    logic [1:0]   rsp_row;
`ifdef CAM_SEQ_PARITY_EN
    logic         rsp_err;
`endif

    cam_row_sequencer #(.WIDTH(W), .PRE_CYCLES(P), .WL_CYCLES(WLC), .REC_CYCLES(R)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_row(req_row), .req_data(req_data),
        .dec_i0(dec_i0), .dec_i1(dec_i1), .dec_en(dec_en), .pre_n(pre_n),
        .bl_drive_en(bl_drive_en), .bl_data(bl_data), .sense_en(sense_en),
        .rd_data(rd_data),
        .rsp_valid(rsp_valid), .rsp_row(rsp_row), .rsp_data(rsp_data),
`ifdef CAM_SEQ_PARITY_EN
        .rsp_err(rsp_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Array contents seen by the sense amps for whichever row the decoder selects.
    logic [W-1:0] mem [4];
    assign rd_data = mem[{dec_i1, dec_i0}];

    // Expected values per clock period (period c = interval after posedge number c).
    bit           e_ready [DEPTH];
    bit           e_pre_n [DEPTH];
    bit           e_en    [DEPTH];
    bit           e_drive [DEPTH];
    bit           e_sense [DEPTH];
    bit           e_rv    [DEPTH];
    bit           e_err   [DEPTH];
    bit           e_blchk [DEPTH];
    logic [1:0]   e_addr  [DEPTH];
    logic [1:0]   e_rrow  [DEPTH];
    logic [W-1:0] e_bl    [DEPTH];
    logic [W-1:0] e_rdata [DEPTH];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] enc(input logic [W-1:0] d);
`ifdef CAM_SEQ_PARITY_EN
        logic [W-1:0] low;
        low = d & 8'h7F;
        return {1'b0, d[W-2:0]} | (($countones(low) % 2 == 1) ? 8'h80 : 8'h00);
`else
        return d;
`endif
    endfunction

    function automatic bit par_bad(input logic [W-1:0] d);
`ifdef CAM_SEQ_PARITY_EN
        return ($countones(d) % 2) != 0;
`else
        return (d != d);
`endif
    endfunction

    function automatic void set_idle(input int from);
        for (int i = from; i < DEPTH; i++) begin
            e_ready[i] = 1; e_pre_n[i] = 1; e_en[i] = 0; e_drive[i] = 0;
            e_sense[i] = 0; e_rv[i] = 0; e_err[i] = 0; e_blchk[i] = 1;
            e_addr[i] = 2'd0; e_rrow[i] = 2'd0; e_bl[i] = '0; e_rdata[i] = '0;
        end
    endfunction

    // Lays out the phase timeline of one accepted request starting at period e.
    function automatic void schedule(input int e, input logic [1:0] op, input logic [1:0] row,
                                     input logic [W-1:0] d);
        int segs;
        int b;
        logic [1:0] r;
        if (op == 2'b11) begin
            e_ready[e] = 0;
            e_blchk[e] = 0;
            return;
        end
        segs = (op == 2'b10) ? 4 : 1;
        for (int s = 0; s < segs; s++) begin
            r = (op == 2'b10) ? 2'(s) : row;
            for (int k = 0; k < N; k++) begin
                b = e + s * N + k;
                e_ready[b] = 0;
                e_addr[b]  = r;
                e_blchk[b] = 0;
                if (k < P) begin
                    e_pre_n[b] = 0;
                end else if (k < P + WLC) begin
                    e_en[b] = 1;
                    if (op == 2'b00) begin
                        e_drive[b] = 1; e_bl[b] = enc(d); e_blchk[b] = 1;
                    end else if (k == P + WLC - 1) begin
                        e_sense[b] = 1;
                    end
                end else if (k == P + WLC && op != 2'b00) begin
                    e_rv[b] = 1; e_rrow[b] = r; e_rdata[b] = mem[r]; e_err[b] = par_bad(mem[r]);
                end
            end
        end
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int c;
        c = cyc;
        if (chk_en && c < DEPTH) begin
            cmp("req_ready", 32'(req_ready), 32'(e_ready[c]));
            cmp("busy", 32'(busy), 32'(!e_ready[c]));
            cmp("pre_n", 32'(pre_n), 32'(e_pre_n[c]));
            cmp("dec_en", 32'(dec_en), 32'(e_en[c]));
            cmp("dec_addr", 32'({dec_i1, dec_i0}), 32'(e_addr[c]));
            cmp("bl_drive_en", 32'(bl_drive_en), 32'(e_drive[c]));
            cmp("sense_en", 32'(sense_en), 32'(e_sense[c]));
            cmp("rsp_valid", 32'(rsp_valid), 32'(e_rv[c]));
            if (e_blchk[c]) cmp("bl_data", 32'(bl_data), 32'(e_bl[c]));
            if (e_rv[c]) begin
                cmp("rsp_row", 32'(rsp_row), 32'(e_rrow[c]));
                cmp("rsp_data", 32'(rsp_data), 32'(e_rdata[c]));
`ifdef CAM_SEQ_PARITY_EN
                cmp("rsp_err", 32'(rsp_err), 32'(e_err[c]));
`endif
            end
            cmp("inv_en_pre", 32'(dec_en & !pre_n), 32'd0);
            cmp("inv_drive_sense", 32'(bl_drive_en & sense_en), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the request until the model says it is taken; e = period of the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [1:0] row, input logic [W-1:0] d,
                         output int e);
        bit ok;
        req_valid = 1'b1; req_op = op; req_row = row; req_data = d;
        for (int i = 0; i < 200; i++) begin
            ok = e_ready[cyc];
            tick();
            if (ok) begin
                e = cyc;
                schedule(e, op, row, d);
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout cyc=%0d got=no_accept exp=accept", cyc);
        e = cyc;
    endtask

    int e, e1, e2;
    logic [W-1:0] scan_vals [4];

    initial begin
        set_idle(0);
        mem[0] = 8'h11; mem[1] = 8'h3C; mem[2] = 8'h33; mem[3] = 8'h44;
        rst_n = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        cmp("rst_ready", 32'(req_ready), 32'd1);
        cmp("rst_pre_n", 32'(pre_n), 32'd1);
        cmp("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        cmp("rst_bl_data", 32'(bl_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Write row 2, 0xA5
        issue(2'b00, 2'd2, 8'hA5, e);
        req_valid = 1'b0;
        cmp("wr_c1_pre_n", 32'(pre_n), 32'd0);
        for (int k = 2; k <= 3; k++) begin
            tick();
            cmp("wr_wl_en", 32'(dec_en), 32'd1);
            cmp("wr_wl_addr", 32'({dec_i1, dec_i0}), 32'd2);
            cmp("wr_wl_data", 32'(bl_data), 32'hA5);
        end
        tick(); tick();
        cmp("wr_c5_ready", 32'(req_ready), 32'd1);
        cmp("wr_c5_bl_clear", 32'(bl_data), 32'd0);
        tick();

        // Read row 1
        issue(2'b01, 2'd1, 8'h00, e);
        req_valid = 1'b0;
        cmp("rd_c1_sense", 32'(sense_en), 32'd0);
        tick();
        cmp("rd_c2_sense", 32'(sense_en), 32'd0);
        tick();
        cmp("rd_c3_sense", 32'(sense_en), 32'd1);
        tick();
        cmp("rd_c4_valid", 32'(rsp_valid), 32'd1);
        cmp("rd_c4_row", 32'(rsp_row), 32'd1);
        cmp("rd_c4_data", 32'(rsp_data), 32'h3C);
        tick();
        cmp("rd_c5_valid", 32'(rsp_valid), 32'd0);
        tick();

        // Scan all rows
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        scan_vals[0] = 8'h11; scan_vals[1] = 8'h22; scan_vals[2] = 8'h33; scan_vals[3] = 8'h44;
        issue(2'b10, 2'd3, 8'h00, e);
        req_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k % 4 == 0) begin
                cmp("scan_valid", 32'(rsp_valid), 32'd1);
                cmp("scan_row", 32'(rsp_row), 32'(k / 4 - 1));
                cmp("scan_data", 32'(rsp_data), 32'(scan_vals[k / 4 - 1]));
            end
            tick();
        end
        cmp("scan_c17_ready", 32'(req_ready), 32'd1);
        tick();

        // Back-to-back with req_valid held high
        mem[0] = 8'h0F;
        issue(2'b00, 2'd3, 8'h5A, e1);
        issue(2'b01, 2'd0, 8'h00, e2);
        req_valid = 1'b0;
        cmp("b2b_accept_gap", 32'(e2 - e1), 32'd5);
        repeat (N + 2) tick();

        // Reset during the wordline phase of a write
        issue(2'b00, 2'd1, 8'hC3, e);
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        set_idle(cyc + 1);
        tick();
        cmp("rstmid_dec_en", 32'(dec_en), 32'd0);
        cmp("rstmid_drive", 32'(bl_drive_en), 32'd0);
        cmp("rstmid_pre_n", 32'(pre_n), 32'd1);
        cmp("rstmid_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        repeat (3) tick();

        // No-op
        issue(2'b11, 2'd2, 8'hFF, e);
        req_valid = 1'b0;
        cmp("nop_c1_ready", 32'(req_ready), 32'd0);
        cmp("nop_c1_pre_n", 32'(pre_n), 32'd1);
        cmp("nop_c1_en", 32'(dec_en), 32'd0);
        tick();
        cmp("nop_c2_ready", 32'(req_ready), 32'd1);
        tick();

`ifdef CAM_SEQ_PARITY_EN
        // Parity: write encoding, then reads with bad and good stored parity
        issue(2'b00, 2'd0, 8'h07, e);
        req_valid = 1'b0;
        tick();
        cmp("par_wr_data", 32'(bl_data), 32'h87);
        repeat (4) tick();
        mem[2] = 8'h01;
        mem[3] = 8'h81;
        issue(2'b01, 2'd2, 8'h00, e);
        req_valid = 1'b0;
        repeat (3) tick();
        cmp("par_bad_err", 32'(rsp_err), 32'd1);
        repeat (2) tick();
        issue(2'b01, 2'd3, 8'h00, e);
        req_valid = 1'b0;
        repeat (3) tick();
        cmp("par_good_err", 32'(rsp_err), 32'd0);
        repeat (2) tick();
`endif

        repeat (2) tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
